// File: rtl/mul16u_share_arb.sv
// Four-requester round-robin front end for one shared 16x16 unsigned multiplier.
// Results return through a credit-limited in-order FIFO tagged with the requester id.
module mul16u_share_arb #(
    parameter int LAT        = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  REQ_VALID,
    output logic [3:0]  REQ_READY,
    input  logic [63:0] REQ_A,
    input  logic [63:0] REQ_B,
    output logic [15:0] MA,
    output logic [15:0] MB,
    input  logic [31:0] MO,
    output logic [31:0] O,
    output logic [1:0]  O_ID,
    output logic        O_VALID,
    input  logic        O_READY,
    output logic        BUSY
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [1:0]    ptr;
    logic [CW-1:0] inflight;
    logic [CW-1:0] count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   mem_data [FIFO_DEPTH];
    logic [1:0]    mem_id   [FIFO_DEPTH];
    logic [LAT:0]  tag_vld;
    logic [1:0]    tag_id   [LAT+1];

    logic [1:0] gnt_idx;
    logic [1:0] idx;
    logic       any_vld;
    logic       can_issue;
    logic       fire;
    logic       push;
    logic       pop;

    // Credits count both ops in the multiplier and results parked in the FIFO,
    // so a push can never find the FIFO full.
    assign can_issue = ({1'b0, inflight} + {1'b0, count}) < (CW+1)'(FIFO_DEPTH);

    always_comb begin
        gnt_idx = '0;
        idx     = '0;
        any_vld = 1'b0;
        // Walk from lowest to highest priority so the highest-priority hit wins.
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (REQ_VALID[idx]) begin
                gnt_idx = idx;
                any_vld = 1'b1;
            end
        end
    end

    assign REQ_READY = (any_vld && can_issue && !rst) ? (4'b0001 << gnt_idx) : 4'b0000;
    assign fire      = |(REQ_VALID & REQ_READY);
    assign push      = tag_vld[LAT];
    assign O_VALID   = (count != '0);
    assign pop       = O_VALID & O_READY;
    assign O         = O_VALID ? mem_data[rd_ptr] : 32'd0;
    assign O_ID      = O_VALID ? mem_id[rd_ptr] : 2'd0;
    assign BUSY      = (inflight != '0) | (count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 2'd0;
            MA  <= 16'd0;
            MB  <= 16'd0;
        end else begin
            if (fire) ptr <= gnt_idx + 2'd1;
            MA <= fire ? REQ_A[{gnt_idx, 4'b0000} +: 16] : 16'd0;
            MB <= fire ? REQ_B[{gnt_idx, 4'b0000} +: 16] : 16'd0;
        end
    end

    // Tag stage k is valid in the cycle the op is k cycles past MA/MB.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= '0;
            for (int k = 0; k <= LAT; k++) tag_id[k] <= 2'd0;
        end else begin
            tag_vld[0] <= fire;
            tag_id[0]  <= gnt_idx;
            for (int k = 1; k <= LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else if (fire && !push) begin
            inflight <= inflight + 1'b1;
        end else if (!fire && push) begin
            inflight <= inflight - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= MO;
            mem_id[wr_ptr]   <= tag_id[LAT];
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && count == CW'(FIFO_DEPTH)));

endmodule
